axi_regbank_responder: RTL and testbench

AXI-lite-style responder holding a small register bank, sitting on the subordinate end of the AXI master's five channels, opposite the `AXI_Master` initiator. Write address and write data are accepted independently, in either order, and committed together. Each committed write returns one write response. Reads return register contents after a programmable wait-state count. It serves as the register-mapped endpoint for master bring-up benches and as the template for peripheral register blocks.

---
 rtl/axi_regbank_responder_if.sv | 40 ++++
 rtl/axi_regbank_responder.sv | 191 +++++++++++++++++++
 tb/tb_axi_regbank_responder.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_regbank_responder_if.sv
// Bus bundle between an AXI-lite-style master and the register-bank responder.
// Carries the five channels: read address (AR), read data (R), write address
// (AW), write data (W) and write response (B). Clock and reset stay outside
// the bundle as plain module ports.
//   master modport : drives addresses, data, valids on AR/AW/W, readies on R/B
//   slave modport  : drives AR/AW/W readies, read data, R/B valids, BRESPONSE
interface axi_regbank_responder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] read_address;
  logic              AR_VALID;
  logic              AR_READY;
  logic [DATA_W-1:0] data_read;
  logic              R_VALID;
  logic              R_READY;
  logic [ADDR_W-1:0] write_address;
  logic              AW_VALID;
  logic              AW_READY;
  logic [DATA_W-1:0] write_data;
  logic              W_VALID;
  logic              W_READY;
  logic              B_VALID;
  logic              B_READY;
  logic [3:0]        BRESPONSE;

  modport master (
    output read_address, AR_VALID, R_READY,
    output write_address, AW_VALID, write_data, W_VALID, B_READY,
    input  AR_READY, data_read, R_VALID,
    input  AW_READY, W_READY, B_VALID, BRESPONSE
  );

  modport slave (
    input  read_address, AR_VALID, R_READY,
    input  write_address, AW_VALID, write_data, W_VALID, B_READY,
    output AR_READY, data_read, R_VALID,
    output AW_READY, W_READY, B_VALID, BRESPONSE
  );
endinterface

// File: rtl/axi_regbank_responder.sv
// Register-bank responder for an AXI-lite-style master.
// Write address and write data are accepted independently and committed
// together; each commit returns one write response. Reads return bank
// contents after READ_WAIT wait states.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - axi_regbank_responder_if.slave (AR, R, AW, W, B channels)
//
// Build option: define AXI_RESP_ERR_EN to answer out-of-range writes with
// BRESPONSE = 4'h2 (SLVERR); otherwise BRESPONSE is always 4'h0.
//
// Write FSM
//   state   | meaning
//   WR_IDLE | waiting for AW and/or W, both readies high
//   WR_ADDR | address held, waiting for W
//   WR_DATA | data held, waiting for AW
//   WR_RESP | write committed, B_VALID high until B handshake
// Read FSM
//   state   | meaning
//   RD_IDLE | waiting for AR, AR_READY high
//   RD_WAIT | counting down wait states
//   RD_DATA | R_VALID high, data_read held until R handshake
module axi_regbank_responder #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 12,
  parameter int READ_WAIT = 1
) (
  input logic                     clk,
  input logic                     rst,
  axi_regbank_responder_if.slave  bus
);

  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;

  wr_state_t         wr_state, wr_next;
  rd_state_t         rd_state, rd_next;
  // Low during reset and the first cycle after release so readies stay 0.
  logic              live;
  logic [DATA_W-1:0] bank [NUM_REGS];
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] rd_data_q;

  logic              aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic              commit;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic              rd_sample;
  logic [ADDR_W-1:0] rd_sample_addr;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [DATA_W-1:0] rd_sample_data;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  assign bus.AW_READY  = live && (wr_state == WR_IDLE || wr_state == WR_DATA);
  assign bus.W_READY   = live && (wr_state == WR_IDLE || wr_state == WR_ADDR);
  assign bus.B_VALID   = (wr_state == WR_RESP);
  assign bus.AR_READY  = live && (rd_state == RD_IDLE);
  assign bus.R_VALID   = (rd_state == RD_DATA);
  assign bus.data_read = rd_data_q;

  assign aw_hs = bus.AW_VALID && bus.AW_READY;
  assign w_hs  = bus.W_VALID  && bus.W_READY;
  assign b_hs  = bus.B_VALID  && bus.B_READY;
  assign ar_hs = bus.AR_VALID && bus.AR_READY;
  assign r_hs  = bus.R_VALID  && bus.R_READY;

  always_comb begin
    wr_next     = wr_state;
    commit      = 1'b0;
    commit_addr = aw_addr_q;
    commit_data = w_data_q;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_next     = WR_RESP;
          commit      = 1'b1;
          commit_addr = bus.write_address;
          commit_data = bus.write_data;
        end else if (aw_hs) begin
          wr_next = WR_ADDR;
        end else if (w_hs) begin
          wr_next = WR_DATA;
        end
      end
      WR_ADDR: begin
        if (w_hs) begin
          wr_next     = WR_RESP;
          commit      = 1'b1;
          commit_data = bus.write_data;
        end
      end
      WR_DATA: begin
        if (aw_hs) begin
          wr_next     = WR_RESP;
          commit      = 1'b1;
          commit_addr = bus.write_address;
        end
      end
      WR_RESP: begin
        if (b_hs) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next        = rd_state;
    rd_sample      = 1'b0;
    rd_sample_addr = ar_addr_q;
    case (rd_state)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_sample_addr = bus.read_address;
          if (READ_WAIT == 0) begin
            rd_next   = RD_DATA;
            rd_sample = 1'b1;
          end else begin
            rd_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (wait_cnt == 4'd0) begin
          rd_next   = RD_DATA;
          rd_sample = 1'b1;
        end
      end
      RD_DATA: begin
        if (r_hs) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // Sampled with the pre-edge bank, so a commit on the same edge is not seen.
  assign rd_sample_data = in_range(rd_sample_addr) ? bank[rd_sample_addr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live      <= 1'b0;
      wr_state  <= WR_IDLE;
      rd_state  <= RD_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      ar_addr_q <= '0;
      wait_cnt  <= '0;
      rd_data_q <= '0;
    end else begin
      live     <= 1'b1;
      wr_state <= wr_next;
      rd_state <= rd_next;
      if (aw_hs) aw_addr_q <= bus.write_address;
      if (w_hs)  w_data_q  <= bus.write_data;
      if (ar_hs) begin
        ar_addr_q <= bus.read_address;
        wait_cnt  <= 4'(READ_WAIT - 1);
      end else if (rd_state == RD_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (rd_sample) rd_data_q <= rd_sample_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else if (commit && in_range(commit_addr)) begin
      bank[commit_addr] <= commit_data;
    end
  end

`ifdef AXI_RESP_ERR_EN
  logic [3:0] bresp_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        bresp_q <= 4'h0;
    else if (commit) bresp_q <= in_range(commit_addr) ? 4'h0 : 4'h2;
  end
  assign bus.BRESPONSE = bresp_q;
`else
  assign bus.BRESPONSE = 4'h0;
`endif

endmodule

// File: tb/tb_axi_regbank_responder.sv
module tb_axi_regbank_responder;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  axi_regbank_responder_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  axi_regbank_responder #(
    .ADDR_W(4), .DATA_W(8), .NUM_REGS(12), .READ_WAIT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef AXI_RESP_ERR_EN
  localparam logic [3:0] OOR_RESP = 4'h2;
`else
  localparam logic [3:0] OOR_RESP = 4'h0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read with bounded waits; lat counts edges from the AR handshake edge
  // (inclusive) to the edge after which R_VALID is seen high.
  task automatic do_read(input logic [3:0] a, output logic [7:0] d, output int lat);
    int guard;
    guard = 0;
    while (!bus.AR_READY && guard < 20) begin tick(); guard++; end
    bus.read_address = a;
    bus.AR_VALID = 1'b1;
    bus.R_READY = 1'b0;
    tick();
    bus.AR_VALID = 1'b0;
    lat = 1;
    while (!bus.R_VALID && lat < 20) begin tick(); lat++; end
    if (!bus.R_VALID) begin
      vectors++; miscompares++;
      $display("FAIL read_timeout addr=%h: R_VALID never rose within %0d cycles", a, lat);
    end
    d = bus.data_read;
    bus.R_READY = 1'b1;
    tick();
    bus.R_READY = 1'b0;
  endtask

  // AW and W together; resp is BRESPONSE while B_VALID is high.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d,
                          output logic [3:0] resp, output int lat);
    int guard;
    guard = 0;
    while (!(bus.AW_READY && bus.W_READY) && guard < 20) begin tick(); guard++; end
    bus.write_address = a;
    bus.write_data = d;
    bus.AW_VALID = 1'b1;
    bus.W_VALID = 1'b1;
    bus.B_READY = 1'b0;
    tick();
    bus.AW_VALID = 1'b0;
    bus.W_VALID = 1'b0;
    lat = 1;
    while (!bus.B_VALID && lat < 20) begin tick(); lat++; end
    if (!bus.B_VALID) begin
      vectors++; miscompares++;
      $display("FAIL write_timeout addr=%h: B_VALID never rose within %0d cycles", a, lat);
    end
    resp = bus.BRESPONSE;
    bus.B_READY = 1'b1;
    tick();
    bus.B_READY = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.read_address = '0; bus.AR_VALID = 1'b0; bus.R_READY = 1'b0;
    bus.write_address = '0; bus.write_data = '0;
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0; bus.B_READY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus.AR_READY, bus.AW_READY, bus.W_READY, bus.R_VALID, bus.B_VALID} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b want=00000",
               {bus.AR_READY, bus.AW_READY, bus.W_READY, bus.R_VALID, bus.B_VALID});
    end
    vectors++;
    if (bus.data_read !== 8'h00 || bus.BRESPONSE !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_data data_read=%h BRESPONSE=%h want 00/0", bus.data_read, bus.BRESPONSE);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    vectors++;
    if ({bus.AR_READY, bus.AW_READY, bus.W_READY} !== 3'b111) begin
      miscompares++;
      $display("FAIL ready_after_release got=%b want=111",
               {bus.AR_READY, bus.AW_READY, bus.W_READY});
    end
  endtask

  task automatic test_single_write();
    logic [7:0] d;
    logic [3:0] resp;
    int lat;
    do_write(4'h6, 8'hAA, resp, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++; $display("FAIL write_latency got=%0d want=1", lat);
    end
    vectors++;
    if (resp !== 4'h0) begin
      miscompares++; $display("FAIL write_resp got=%h want=0", resp);
    end
    do_read(4'h6, d, lat);
    vectors++;
    if (d !== 8'hAA) begin
      miscompares++; $display("FAIL readback_6 got=%h want=aa", d);
    end
    vectors++;
    if (lat !== 2) begin
      miscompares++; $display("FAIL read_latency got=%0d want=2", lat);
    end
  endtask

  task automatic test_split_write();
    logic [7:0] d;
    int lat;
    bus.write_data = 8'h5C;
    bus.W_VALID = 1'b1;
    bus.B_READY = 1'b1;
    tick();
    bus.W_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.AW_READY !== 1'b1 || bus.W_READY !== 1'b0 || bus.B_VALID !== 1'b0) begin
        miscompares++;
        $display("FAIL split_hold cyc=%0d AW_READY=%b W_READY=%b B_VALID=%b want 1/0/0",
                 i, bus.AW_READY, bus.W_READY, bus.B_VALID);
      end
      if (i < 2) tick();
    end
    bus.write_address = 4'h3;
    bus.AW_VALID = 1'b1;
    tick();
    bus.AW_VALID = 1'b0;
    vectors++;
    if (bus.B_VALID !== 1'b1 || bus.BRESPONSE !== 4'h0) begin
      miscompares++;
      $display("FAIL split_bvalid B_VALID=%b BRESPONSE=%h want 1/0", bus.B_VALID, bus.BRESPONSE);
    end
    tick();
    bus.B_READY = 1'b0;
    vectors++;
    if (bus.B_VALID !== 1'b0) begin
      miscompares++; $display("FAIL split_bdone B_VALID=%b want 0", bus.B_VALID);
    end
    do_read(4'h3, d, lat);
    vectors++;
    if (d !== 8'h5C) begin
      miscompares++; $display("FAIL readback_3 got=%h want=5c", d);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    int lat;
    bus.R_READY = 1'b0;
    bus.B_READY = 1'b0;
    bus.read_address = 4'h6;
    bus.AR_VALID = 1'b1;
    bus.write_address = 4'h1;
    bus.write_data = 8'h77;
    bus.AW_VALID = 1'b1;
    bus.W_VALID = 1'b1;
    tick();
    // Master now offers a new write and read that must be ignored.
    bus.read_address = 4'h3;
    bus.write_address = 4'h2;
    bus.write_data = 8'h33;
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.R_VALID !== 1'b1 || bus.B_VALID !== 1'b1 ||
          bus.data_read !== 8'hAA || bus.BRESPONSE !== 4'h0) begin
        miscompares++;
        $display("FAIL bp_hold cyc=%0d R_VALID=%b B_VALID=%b data_read=%h BRESPONSE=%h want 1/1/aa/0",
                 i, bus.R_VALID, bus.B_VALID, bus.data_read, bus.BRESPONSE);
      end
      vectors++;
      if (bus.AW_READY !== 1'b0 || bus.AR_READY !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_ready cyc=%0d AW_READY=%b AR_READY=%b want 0/0",
                 i, bus.AW_READY, bus.AR_READY);
      end
      tick();
    end
    bus.AR_VALID = 1'b0;
    bus.AW_VALID = 1'b0;
    bus.W_VALID = 1'b0;
    bus.R_READY = 1'b1;
    bus.B_READY = 1'b1;
    tick();
    bus.R_READY = 1'b0;
    bus.B_READY = 1'b0;
    vectors++;
    if (bus.R_VALID !== 1'b0 || bus.B_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release R_VALID=%b B_VALID=%b want 0/0", bus.R_VALID, bus.B_VALID);
    end
    do_read(4'h1, d, lat);
    vectors++;
    if (d !== 8'h77) begin
      miscompares++; $display("FAIL readback_1 got=%h want=77", d);
    end
    do_read(4'h2, d, lat);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++; $display("FAIL ignored_write_2 got=%h want=00", d);
    end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    int lat;
    bus.read_address = 4'h6;
    bus.AR_VALID = 1'b1;
    bus.R_READY = 1'b0;
    tick();
    bus.AR_VALID = 1'b0;
    // The next edge both samples data_read and commits this write.
    bus.write_address = 4'h6;
    bus.write_data = 8'h11;
    bus.AW_VALID = 1'b1;
    bus.W_VALID = 1'b1;
    bus.B_READY = 1'b1;
    tick();
    bus.AW_VALID = 1'b0;
    bus.W_VALID = 1'b0;
    vectors++;
    if (bus.R_VALID !== 1'b1 || bus.B_VALID !== 1'b1 || bus.data_read !== 8'hAA) begin
      miscompares++;
      $display("FAIL collision R_VALID=%b B_VALID=%b data_read=%h want 1/1/aa",
               bus.R_VALID, bus.B_VALID, bus.data_read);
    end
    bus.R_READY = 1'b1;
    tick();
    bus.R_READY = 1'b0;
    bus.B_READY = 1'b0;
    do_read(4'h6, d, lat);
    vectors++;
    if (d !== 8'h11) begin
      miscompares++; $display("FAIL after_collision got=%h want=11", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] d;
    logic [3:0] resp;
    int lat;
    do_write(4'hE, 8'hFF, resp, lat);
    vectors++;
    if (resp !== OOR_RESP) begin
      miscompares++; $display("FAIL oor_resp got=%h want=%h", resp, OOR_RESP);
    end
    do_read(4'hE, d, lat);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++; $display("FAIL oor_read got=%h want=00", d);
    end
    do_write(4'hB, 8'h42, resp, lat);
    vectors++;
    if (resp !== 4'h0) begin
      miscompares++; $display("FAIL last_reg_resp got=%h want=0", resp);
    end
    do_read(4'hB, d, lat);
    vectors++;
    if (d !== 8'h42) begin
      miscompares++; $display("FAIL readback_b got=%h want=42", d);
    end
    do_write(4'hC, 8'h99, resp, lat);
    do_read(4'hC, d, lat);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++; $display("FAIL first_oor_read got=%h want=00", d);
    end
    do_read(4'h6, d, lat);
    vectors++;
    if (d !== 8'h11) begin
      miscompares++; $display("FAIL bank_unchanged_6 got=%h want=11", d);
    end
    do_read(4'h3, d, lat);
    vectors++;
    if (d !== 8'h5C) begin
      miscompares++; $display("FAIL bank_unchanged_3 got=%h want=5c", d);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] d;
    int lat;
    bus.write_address = 4'h5;
    bus.AW_VALID = 1'b1;
    tick();
    bus.AW_VALID = 1'b0;
    vectors++;
    if (bus.AW_READY !== 1'b0 || bus.W_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_addr_held AW_READY=%b W_READY=%b want 0/1", bus.AW_READY, bus.W_READY);
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.AR_READY, bus.AW_READY, bus.W_READY, bus.R_VALID, bus.B_VALID} !== 5'b0 ||
        bus.data_read !== 8'h00 || bus.BRESPONSE !== 4'h0) begin
      miscompares++;
      $display("FAIL async_reset ctrl=%b data_read=%h BRESPONSE=%h want 00000/00/0",
               {bus.AR_READY, bus.AW_READY, bus.W_READY, bus.R_VALID, bus.B_VALID},
               bus.data_read, bus.BRESPONSE);
    end
    bus.write_data = 8'h99;
    bus.W_VALID = 1'b1;
    tick();
    bus.W_VALID = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    vectors++;
    if ({bus.AR_READY, bus.AW_READY, bus.W_READY, bus.R_VALID, bus.B_VALID} !== 5'b11100) begin
      miscompares++;
      $display("FAIL idle_after_reset got=%b want=11100",
               {bus.AR_READY, bus.AW_READY, bus.W_READY, bus.R_VALID, bus.B_VALID});
    end
    for (int a = 0; a < 12; a++) begin
      do_read(4'(a), d, lat);
      vectors++;
      if (d !== 8'h00) begin
        miscompares++; $display("FAIL bank_cleared addr=%0d got=%h want=00", a, d);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_write();
    test_split_write();
    test_backpressure();
    test_collision();
    test_out_of_range();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
